// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: screens commands, issues one ALU start, and returns result, status and latency.
module alu_seq_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_dtype,
    input  logic [4:0]  cmd_op,
    input  logic [15:0] cmd_src1,
    input  logic [15:0] cmd_src2,
    output logic        alu_start,
    output logic [3:0]  alu_dtype,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_err,
    output logic [7:0]  rsp_cycles,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [3:0]  dtype_q, dtype_d;
    logic [4:0]  op_q, op_d;
    logic [15:0] src1_q, src1_d, src2_q, src2_d;
    logic [7:0]  cnt_q, cnt_d, cyc_q, cyc_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  err_q, err_d;
    logic        start_q, start_d, ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        dtype_d = dtype_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                dtype_d = cmd_dtype;
                op_d    = cmd_op;
                src1_d  = cmd_src1;
                src2_d  = cmd_src2;
                state_d = CHECK;
            end
            CHECK: if ((op_q != OP_DIV) && (op_q != OP_MUL)) begin
                {res_d, cyc_d, err_d} = {32'd0, 8'd0, 2'd1};
                state_d = RESP;
            end else if ((op_q == OP_DIV) && (src2_q == 16'd0)) begin
                {res_d, cyc_d, err_d} = {32'd0, 8'd0, 2'd2};
                state_d = RESP;
            end else begin
                state_d = ISSUE;
            end
            // counter reads 1 in the first WAIT cycle, so it equals cycles since the start pulse
            ISSUE: begin
                cnt_d   = 8'd1;
                state_d = WAIT;
            end
            WAIT: if (alu_done) begin
                {res_d, cyc_d, err_d} = {alu_result, cnt_q, 2'd0};
                state_d = RESP;
            end else if (cnt_q == TMO) begin
                {res_d, cyc_d, err_d} = {32'd0, 8'd0, 2'd3};
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        start_d = state_d == ISSUE;
        ready_d = state_d == IDLE;
        valid_d = state_d == RESP;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            dtype_q <= '0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            res_q   <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dtype_q <= dtype_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            res_q   <= res_d;
            err_q   <= err_d;
            start_q <= start_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign alu_start  = start_q;
    assign alu_dtype  = dtype_q;
    assign alu_op     = op_q;
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign rsp_valid  = valid_q;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;
    assign rsp_cycles = cyc_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of alu_seq_ctrl against a behavioural ALU and response model.
module tb_alu_seq_ctrl;
    localparam logic [4:0] DIV = 5'b01000;
    localparam logic [4:0] MUL = 5'b00100;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_dtype;
    logic [4:0]  cmd_op;
    logic [15:0] cmd_src1, cmd_src2;
    logic        alu_start;
    logic [3:0]  alu_dtype;
    logic [4:0]  alu_op;
    logic [15:0] alu_src1, alu_src2;
    logic        alu_done, model_done, late_done;
    logic [31:0] alu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_err;
    logic [7:0]  rsp_cycles;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int alu_lat = 17;
    bit alu_never = 1'b0;
    int start_cnt = 0;
    int unstable = 0;

    assign alu_done = model_done | late_done;

    logic [86:0] outs;
    assign outs = {cmd_ready, alu_start, busy, rsp_valid, rsp_err, rsp_cycles, rsp_result,
                   alu_op, alu_dtype, alu_src1, alu_src2};
    localparam logic [86:0] RESET_OUTS = {1'b1, 86'd0};

    alu_seq_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dtype(cmd_dtype), .cmd_op(cmd_op),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .alu_start(alu_start), .alu_dtype(alu_dtype), .alu_op(alu_op),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_cycles(rsp_cycles), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] calc(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q, r;
        if (op == MUL) return 32'(a) * 32'(b);
        q = (b == 0) ? 16'd0 : a / b;
        r = (b == 0) ? 16'd0 : a % b;
        return {q, r};
    endfunction

    // Behavioural ALU: done pulses alu_lat cycles after the start cycle; result is junk otherwise.
    initial begin
        int rem;
        logic [15:0] h1, h2;
        logic [4:0] hop;
        rem = 0;
        h1 = 0; h2 = 0; hop = 0;
        model_done = 1'b0;
        alu_result = 32'd0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            alu_result = $urandom;
            if (!n_rst) begin
                rem = 0;
            end else if (alu_start) begin
                start_cnt++;
                h1 = alu_src1; h2 = alu_src2; hop = alu_op;
                rem = alu_never ? 0 : alu_lat;
            end else if (rem > 0) begin
                if (alu_src1 !== h1 || alu_src2 !== h2) unstable++;
                rem--;
                if (rem == 0) begin
                    model_done = 1'b1;
                    alu_result = calc(hop, h1, h2);
                end
            end
        end
    end

    task automatic send(input logic [3:0] dt, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dtype = dt; cmd_op = op; cmd_src1 = a; cmd_src2 = b;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL send_accept: cmd_ready=%b required 1", cmd_ready);
        else passed++;
        @(posedge clk);
    endtask

    task automatic wait_rsp(input bit hold, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 400);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (outs !== RESET_OUTS) $display("FAIL reset_outputs: got %h required %h", outs, RESET_OUTS);
        else passed++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== RESET_OUTS) $display("FAIL reset_idle: got %h required %h", outs, RESET_OUTS);
        else passed++;
    endtask

    task automatic test_multiply();
        int lat, s0, u0;
        alu_lat = 17; s0 = start_cnt; u0 = unstable;
        send(4'h1, MUL, 16'd3, 16'd5);
        wait_rsp(1'b0, lat);
        checks++;
        if (lat != 20) $display("FAIL mul_latency: got %0d required 20", lat); else passed++;
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'd15, 2'd0, 8'd17})
            $display("FAIL mul_rsp: got result=%0d err=%0d cycles=%0d required 15/0/17", rsp_result, rsp_err, rsp_cycles);
        else passed++;
        checks++;
        if (start_cnt - s0 != 1) $display("FAIL mul_starts: got %0d required 1", start_cnt - s0); else passed++;
        checks++;
        if (unstable != u0 || alu_src1 !== 16'd3 || alu_src2 !== 16'd5 || alu_dtype !== 4'h1)
            $display("FAIL mul_hold: unstable=%0d src1=%0d src2=%0d required 0/3/5", unstable - u0, alu_src1, alu_src2);
        else passed++;
        take_rsp();
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100)
            $display("FAIL mul_idle: got ready/busy/valid=%b required 100", {cmd_ready, busy, rsp_valid});
        else passed++;
    endtask

    task automatic test_divide();
        int lat;
        alu_lat = 9;
        send(4'h2, DIV, 16'd100, 16'd7);
        wait_rsp(1'b0, lat);
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'h000E0002, 2'd0, 8'd9} || lat != 12)
            $display("FAIL div_rsp: got result=%h err=%0d cycles=%0d lat=%0d required 000e0002/0/9/12", rsp_result, rsp_err, rsp_cycles, lat);
        else passed++;
        take_rsp();
    endtask

    task automatic test_errors();
        int lat, s0;
        s0 = start_cnt;
        send(4'h0, DIV, 16'd55, 16'd0);
        wait_rsp(1'b0, lat);
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'd0, 2'd2, 8'd0} || lat != 2)
            $display("FAIL div_zero: got result=%h err=%0d lat=%0d required 0/2/2", rsp_result, rsp_err, lat);
        else passed++;
        take_rsp();
        send(4'h0, 5'b00001, 16'd9, 16'd4);
        wait_rsp(1'b0, lat);
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'd0, 2'd1, 8'd0} || lat != 2)
            $display("FAIL unsupported: got result=%h err=%0d lat=%0d required 0/1/2", rsp_result, rsp_err, lat);
        else passed++;
        take_rsp();
        checks++;
        if (start_cnt != s0) $display("FAIL error_no_start: got %0d starts required 0", start_cnt - s0); else passed++;
    endtask

    task automatic test_timeout();
        int lat;
        alu_never = 1'b1;
        send(4'h3, MUL, 16'd1234, 16'd77);
        wait_rsp(1'b0, lat);
        alu_never = 1'b0;
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'd0, 2'd3, 8'd0} || lat != 67)
            $display("FAIL timeout: got result=%h err=%0d cycles=%0d lat=%0d required 0/3/0/67", rsp_result, rsp_err, rsp_cycles, lat);
        else passed++;
        late_done = 1'b1;
        @(negedge clk);
        late_done = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result, rsp_err, rsp_cycles} !== {1'b1, 32'd0, 2'd3, 8'd0})
            $display("FAIL late_done_resp: got valid=%b result=%h err=%0d required 1/0/3", rsp_valid, rsp_result, rsp_err);
        else passed++;
        take_rsp();
        late_done = 1'b1;
        @(negedge clk);
        late_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_err} !== 5'b10011)
            $display("FAIL late_done_idle: got ready/busy/valid/err=%b required 10011", {cmd_ready, busy, rsp_valid, rsp_err});
        else passed++;
    endtask

    task automatic test_done_at_limit();
        int lat;
        alu_lat = 64;
        send(4'h1, MUL, 16'd300, 16'd400);
        wait_rsp(1'b0, lat);
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'd120000, 2'd0, 8'd64} || lat != 67)
            $display("FAIL done_at_limit: got result=%0d err=%0d cycles=%0d lat=%0d required 120000/0/64/67", rsp_result, rsp_err, rsp_cycles, lat);
        else passed++;
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        alu_lat = 4;
        send(4'h1, MUL, 16'd7, 16'd9);
        wait_rsp(1'b1, lat);
        cmd_op = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_result, rsp_err, rsp_cycles, cmd_ready, busy} !== {1'b1, 32'd63, 2'd0, 8'd4, 1'b0, 1'b1})
                $display("FAIL backpressure_hold: cycle %0d valid=%b result=%0d cycles=%0d ready=%b busy=%b required 1/63/4/0/1", i, rsp_valid, rsp_result, rsp_cycles, cmd_ready, busy);
            else passed++;
            @(negedge clk);
        end
        take_rsp();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) $display("FAIL handshake_idle: got ready/busy=%b required 10", {cmd_ready, busy});
        else passed++;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, busy} !== 2'b01) $display("FAIL next_accept: got ready/busy=%b required 01", {cmd_ready, busy});
        else passed++;
        wait_rsp(1'b0, lat);
        checks++;
        if (rsp_err !== 2'd1 || lat != 1) $display("FAIL next_rsp: got err=%0d lat=%0d required 1/1", rsp_err, lat);
        else passed++;
        take_rsp();
    endtask

    task automatic test_reset_wait();
        int n = 0, lat;
        bit seen = 1'b0;
        alu_lat = 17;
        send(4'h1, MUL, 16'd3, 16'd5);
        while (!alu_start && n < 20) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
        end
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (outs !== RESET_OUTS) $display("FAIL reset_in_wait: got %h required %h", outs, RESET_OUTS);
        else passed++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL reset_no_rsp: got stray activity=1 required 0");
        else passed++;
        alu_lat = 11;
        send(4'h1, MUL, 16'd21, 16'd2);
        wait_rsp(1'b0, lat);
        checks++;
        if ({rsp_result, rsp_err, rsp_cycles} !== {32'd42, 2'd0, 8'd11} || lat != 14)
            $display("FAIL after_reset_mul: got result=%0d err=%0d cycles=%0d lat=%0d required 42/0/11/14", rsp_result, rsp_err, rsp_cycles, lat);
        else passed++;
        take_rsp();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int lat, s0, kind;
            logic [4:0] op;
            logic [15:0] a, b;
            logic [1:0] e_err;
            logic [31:0] e_res;
            logic [7:0] e_cyc;
            int e_lat;
            kind = $urandom_range(0, 3);
            a = 16'($urandom);
            b = 16'($urandom);
            op = (kind == 0) ? MUL : (kind == 2) ? 5'($urandom) : DIV;
            if (kind == 3) b = 16'd0;
            alu_lat = $urandom_range(1, 40);
            e_err = (op != MUL && op != DIV) ? 2'd1 : (op == DIV && b == 0) ? 2'd2 : 2'd0;
            e_res = (e_err == 0) ? calc(op, a, b) : 32'd0;
            e_cyc = (e_err == 0) ? 8'(alu_lat) : 8'd0;
            e_lat = (e_err == 0) ? 3 + alu_lat : 2;
            s0 = start_cnt;
            send(4'($urandom), op, a, b);
            wait_rsp(1'b0, lat);
            checks++;
            if ({rsp_result, rsp_err, rsp_cycles} !== {e_res, e_err, e_cyc} || lat != e_lat || start_cnt - s0 != (e_err == 0 ? 1 : 0))
                $display("FAIL random_%0d: op=%b got result=%h err=%0d cycles=%0d lat=%0d starts=%0d required %h/%0d/%0d/%0d",
                         i, op, rsp_result, rsp_err, rsp_cycles, lat, start_cnt - s0, e_res, e_err, e_cyc, e_lat);
            else passed++;
            take_rsp();
        end
    endtask

    initial begin
        n_rst = 1'b0;
        cmd_valid = 1'b0; cmd_dtype = 0; cmd_op = 0; cmd_src1 = 0; cmd_src2 = 0;
        rsp_ready = 1'b0; late_done = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        test_reset();
        test_multiply();
        test_divide();
        test_errors();
        test_timeout();
        test_done_at_limit();
        test_back_to_back();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
